// File: rtl/if_id_pipe_buf.sv
// if_id_pipe_buf: IF/ID pipeline buffer between fetch and decode.
//
// This is a DEPTH-entry in-order queue. Each entry carries the next PC, the
// instruction word and the I-cache hit flag. The buffer provides a valid/ready
// handshake on both sides, a synchronous flush, an optional miss-drop mode and
// a saturating stall counter.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready fetch-side handshake
//   in_pc/in_instr/in_hit  entry pushed by fetch
//   flush             synchronous flush (branch redirect); beats push and pop
//   out_valid/out_ready    decode-side handshake
//   out_pc/out_instr/out_hit  head entry (last stored contents when empty)
//   count             occupied entries
//   stall_cnt         saturating count of decode back-pressure cycles
module if_id_pipe_buf #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned DROP_MISS = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_hit,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic                     out_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam logic [PtrW:0] Full   = (PtrW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] StallMax = '1;
    localparam bit DropEn            = (DROP_MISS != 0);

    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]      count_q, count_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic               hit_mem_q   [DEPTH];

    logic accept;
    logic pop;
    logic drop;

    // Handshake: in_ready comes from registered occupancy only, so a pop on a
    // full buffer never opens the input in the same cycle.
    always_comb begin
        in_ready  = (count_q != Full);
        out_valid = (count_q != '0);
        drop      = DropEn && !in_hit;
        // A dropped miss still completes the handshake, it just is not stored.
        accept    = in_valid && in_ready && !flush && !drop;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (out_valid && !out_ready && !flush && (stall_q != StallMax)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is reset so the head outputs read as zero out of reset.
    // Flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                hit_mem_q[i]   <= 1'b0;
            end
        end else if (accept) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
            hit_mem_q[wr_ptr_q]   <= in_hit;
        end
    end

    always_comb begin
        out_pc    = pc_mem_q[rd_ptr_q];
        out_instr = instr_mem_q[rd_ptr_q];
        out_hit   = hit_mem_q[rd_ptr_q];
        count     = count_q;
        stall_cnt = stall_q;
    end

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Bench for if_id_pipe_buf. Instance a: DEPTH=2, DROP_MISS=0, CNT_W=4.
// Instance b: DEPTH=4, DROP_MISS=1, CNT_W=6. Both instances share all inputs.
module tb_if_id_pipe_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_hit = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_hit_a;
    logic [31:0] out_pc_a, out_instr_a;
    logic [1:0]  count_a;
    logic [3:0]  stall_a;

    logic        in_ready_b, out_valid_b, out_hit_b;
    logic [31:0] out_pc_b, out_instr_b;
    logic [2:0]  count_b;
    logic [5:0]  stall_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_pipe_buf #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .DROP_MISS(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(in_pc), .in_instr(in_instr), .in_hit(in_hit), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .out_instr(out_instr_a), .out_hit(out_hit_a), .count(count_a),
        .stall_cnt(stall_a)
    );

    if_id_pipe_buf #(.PC_W(32), .INSTR_W(32), .DEPTH(4), .DROP_MISS(1), .CNT_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_instr(in_instr), .in_hit(in_hit), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .out_instr(out_instr_b), .out_hit(out_hit_b), .count(count_b),
        .stall_cnt(stall_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic hit, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        in_hit    = hit;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Reference model: plain queues ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        hit;
    } ent_t;

    ent_t mq [2][$];
    int   mstall [2];
    int   mdepth [2] = '{2, 4};
    bit   mdrop  [2] = '{1'b0, 1'b1};
    int   mcmax  [2] = '{15, 63};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = {};
            mstall[i] = 0;
        end
    endtask

    // Called after an edge; inputs still hold their pre-edge values.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit   full, valid, acc, pp;
            ent_t e;
            full  = (mq[i].size() == mdepth[i]);
            valid = (mq[i].size() != 0);
            acc   = in_valid && !full && !flush && !(mdrop[i] && !in_hit);
            pp    = valid && out_ready && !flush;
            if (valid && !out_ready && !flush && mstall[i] < mcmax[i]) mstall[i]++;
            e.pc = in_pc; e.instr = in_instr; e.hit = in_hit;
            if (flush) begin
                mq[i] = {};
            end else begin
                if (pp) void'(mq[i].pop_front());
                if (acc) mq[i].push_back(e);
            end
        end
    endtask

    task automatic model_compare();
        chk("a.out_valid", 64'(out_valid_a), 64'(mq[0].size() != 0));
        chk("a.count",     64'(count_a),     64'(mq[0].size()));
        chk("a.in_ready",  64'(in_ready_a),  64'(mq[0].size() != 2));
        chk("a.stall_cnt", 64'(stall_a),     64'(mstall[0]));
        if (mq[0].size() != 0) begin
            chk("a.out_pc",    64'(out_pc_a),    64'(mq[0][0].pc));
            chk("a.out_instr", 64'(out_instr_a), 64'(mq[0][0].instr));
            chk("a.out_hit",   64'(out_hit_a),   64'(mq[0][0].hit));
        end
        chk("b.out_valid", 64'(out_valid_b), 64'(mq[1].size() != 0));
        chk("b.count",     64'(count_b),     64'(mq[1].size()));
        chk("b.in_ready",  64'(in_ready_b),  64'(mq[1].size() != 4));
        chk("b.stall_cnt", 64'(stall_b),     64'(mstall[1]));
        if (mq[1].size() != 0) begin
            chk("b.out_pc",    64'(out_pc_b),    64'(mq[1][0].pc));
            chk("b.out_instr", 64'(out_instr_b), 64'(mq[1][0].instr));
            chk("b.out_hit",   64'(out_hit_b),   64'(mq[1][0].hit));
        end
    endtask

    // ---------------- Directed vector table (instance a) ----------------
    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        ordy;
        logic        e_valid;
        logic [1:0]  e_count;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [3:0]  e_stall;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                           input logic fl, input logic ordy, input logic ev,
                           input logic [1:0] ec, input logic er, input logic [31:0] epc,
                           input logic [31:0] ein, input logic [3:0] es);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.ordy = ordy;
        v.e_valid = ev; v.e_count = ec; v.e_ready = er; v.e_pc = epc;
        v.e_instr = ein; v.e_stall = es;
        vecs.push_back(v);
    endtask

    initial begin
        // Single push after reset, then fill/back-pressure, then drain.
        add_vec(1, 10, 7,   0, 0, 1, 1, 1, 10, 7,   0);
        add_vec(1, 3,  103, 0, 0, 1, 2, 0, 10, 7,   1);
        add_vec(1, 5,  105, 0, 0, 1, 2, 0, 10, 7,   2);  // refused: full
        add_vec(0, 0,  0,   0, 0, 1, 2, 0, 10, 7,   3);
        add_vec(0, 0,  0,   0, 1, 1, 1, 1, 3,  103, 3);
        add_vec(0, 0,  0,   0, 1, 0, 0, 1, 0,  0,   3);
        // Back-to-back push+pop at count=1: head follows the newest PC.
        add_vec(1, 20, 120, 0, 1, 1, 1, 1, 20, 120, 3);
        for (int k = 21; k <= 28; k++) begin
            add_vec(1, 32'(k), 32'(k + 100), 0, 1, 1, 1, 1, 32'(k), 32'(k + 100), 3);
        end
        add_vec(0, 0,  0,   0, 1, 0, 0, 1, 0,  0,   3);
        // Flush at count=2 with concurrent push and pop.
        add_vec(1, 30, 130, 0, 0, 1, 1, 1, 30, 130, 3);
        add_vec(1, 31, 131, 0, 0, 1, 2, 0, 30, 130, 4);
        add_vec(1, 32, 132, 1, 1, 0, 0, 1, 0,  0,   4);
        add_vec(0, 0,  0,   0, 0, 0, 0, 1, 0,  0,   4);  // pushed entry absent

        // Reset: hold low for 2 edges, outputs all idle.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst.count",     64'(count_a),     64'(0));
        chk("rst.out_valid", 64'(out_valid_a), 64'(0));
        chk("rst.in_ready",  64'(in_ready_a),  64'(1));
        chk("rst.stall_cnt", 64'(stall_a),     64'(0));
        chk("rst.out_pc",    64'(out_pc_a),    64'(0));
        chk("rst.out_instr", 64'(out_instr_a), 64'(0));
        chk("rst.out_hit",   64'(out_hit_a),   64'(0));
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].iv, vecs[k].pc, vecs[k].instr, 1'b1, vecs[k].fl, vecs[k].ordy);
            tick();
            chk($sformatf("vec%0d.out_valid", k), 64'(out_valid_a), 64'(vecs[k].e_valid));
            chk($sformatf("vec%0d.count", k),     64'(count_a),     64'(vecs[k].e_count));
            chk($sformatf("vec%0d.in_ready", k),  64'(in_ready_a),  64'(vecs[k].e_ready));
            chk($sformatf("vec%0d.stall_cnt", k), 64'(stall_a),     64'(vecs[k].e_stall));
            if (vecs[k].e_valid) begin
                chk($sformatf("vec%0d.out_pc", k),    64'(out_pc_a),    64'(vecs[k].e_pc));
                chk($sformatf("vec%0d.out_instr", k), 64'(out_instr_a), 64'(vecs[k].e_instr));
                chk($sformatf("vec%0d.out_hit", k),   64'(out_hit_a),   64'(1));
            end
        end

        // Stall counter saturation on a (CNT_W=4), then async reset between edges.
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1, 50, 150, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) tick();
        chk("sat.stall_cnt", 64'(stall_a), 64'(15));
        tick();
        chk("sat.hold", 64'(stall_a), 64'(15));
        chk("sat.count", 64'(count_a), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.stall_cnt", 64'(stall_a),     64'(0));
        chk("arst.count",     64'(count_a),     64'(0));
        chk("arst.out_valid", 64'(out_valid_a), 64'(0));
        #1;
        rst_n = 1'b1;

        // Drop-miss on b, out_ready=1 throughout.
        drive(1, 3, 103, 0, 0, 1);
        #1;
        chk("drop.in_ready_miss", 64'(in_ready_b), 64'(1));
        tick();
        chk("drop.count_after_miss", 64'(count_b),     64'(0));
        chk("drop.valid_after_miss", 64'(out_valid_b), 64'(0));
        drive(1, 4, 104, 1, 0, 1);
        #1;
        chk("drop.in_ready_hit", 64'(in_ready_b), 64'(1));
        tick();
        chk("drop.valid_hit", 64'(out_valid_b), 64'(1));
        chk("drop.pc_hit",    64'(out_pc_b),    64'(4));
        chk("drop.count_hit", 64'(count_b),     64'(1));
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("drop.count_drain", 64'(count_b), 64'(0));

        // Randomized traffic checked against the queue model on both instances.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0));
            tick();
            model_edge();
            model_compare();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_buf.md
# if_id_pipe_buf

Parametrised IF/ID pipeline buffer that sits between the fetch stage and the decode stage. It replaces a single-entry, always-capturing IF/ID register with a DEPTH-entry in-order queue that carries the next PC, the instruction word and the I-cache hit flag. The queue adds a valid/ready handshake, a flush, an optional miss-drop mode and a saturating stall counter. Fetch pushes at most one instruction per cycle and decode pops at most one per cycle.

## Interface

Parameters:
- PC_W, 32, width of the next-PC field
- INSTR_W, 32, width of the instruction field
- DEPTH, 2, number of queue entries; a power of two, at least 2
- DROP_MISS, 0, when 1, pushes with in_hit=0 are discarded as bubbles
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  buffer can accept an entry this cycle
- in_pc  in  PC_W  next PC from fetch
- in_instr  in  INSTR_W  instruction word
- in_hit  in  1  I-cache hit flag
- flush  in  1  synchronous flush (branch redirect)
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  PC_W  head next PC
- out_instr  out  INSTR_W  head instruction
- out_hit  out  1  head hit flag
- count  out  clog2(DEPTH)+1  number of occupied entries
- stall_cnt  out  CNT_W  saturating count of decode back-pressure cycles

## Operation

- The storage is a circular array with a write pointer, a read pointer and an occupancy counter. Both pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from out_ready.
- accept = in_valid & in_ready & ~flush & ~(DROP_MISS & ~in_hit).
- A push writes {in_pc, in_instr, in_hit} at the write pointer and advances it.
- pop = out_valid & out_ready & ~flush. A pop advances the read pointer.
- out_valid = (count != 0). out_pc, out_instr and out_hit always show the entry at the read pointer, or the last stored contents when the buffer is empty.
- If accept and pop occur in the same cycle, count is unchanged. This applies at any occupancy, including count=DEPTH-1.
- When full, a same-cycle pop does not enable a push. in_ready stays 0 for that cycle.
- flush has priority over push and pop in the same cycle:
  - both pointers and count go to 0;
  - entry storage is left unchanged;
  - stall_cnt is not affected.
- With DROP_MISS=1, a push with in_hit=0 is handshaken normally (in_ready as usual) but is not stored. The fetch side sees it as consumed.
- stall_cnt increments on every cycle with out_valid=1 and out_ready=0 and flush=0. It saturates at 2^CNT_W−1 and is cleared only by reset.

## Timing

- rst_n=0 forces the following asynchronously:
  - pointers, count and stall_cnt to 0;
  - out_valid to 0 and in_ready to 1;
  - out_pc, out_instr and out_hit to 0, because storage entries reset to 0.
- Push to visible latency is 1 cycle. An entry accepted at edge N gives out_valid=1 with its data after edge N; there is no same-cycle bypass.
- A pop at edge N shows the next entry, or out_valid=0, after edge N.
- Flush at edge N gives out_valid=0, count=0 and in_ready=1 after edge N.
- Asserting rst_n low mid-operation discards all entries immediately.
- After rst_n deasserts, the first push is allowed on the first rising edge.

## Test plan

- Reset then single push:
  - Stimulus: rst_n low for 2 cycles, then in_valid=1, in_pc=10, in_instr=7, in_hit=1 for one edge, out_ready=0.
  - Required: after that edge, out_valid=1, out_pc=10, out_instr=7, out_hit=1, count=1.
- Fill and back-pressure (DEPTH=2):
  - Stimulus: push pc=10, then pc=3, with out_ready=0.
  - Required: in_ready=0 and count=2; stall_cnt increases by 1 per held cycle; a third push is refused.
  - Then out_ready=1: out_pc shows 10, then 3, then out_valid=0.
- Simultaneous push and pop at count=1:
  - Required: count stays 1, out_pc takes the new PC, and order is preserved over 8 back-to-back transfers.
- Flush with concurrent push and pop at count=2:
  - Required: next cycle count=0, out_valid=0, in_ready=1, and the pushed entry is absent.
- DROP_MISS=1, with out_ready=1 throughout:
  - Stimulus: push pc=3 with in_hit=0, then pc=4 with in_hit=1.
  - Required: in_ready=1 for both pushes; only pc=4 appears at the output, and count never exceeds 1.
- Async reset and stall_cnt saturation (CNT_W=4):
  - Stimulus: hold out_valid=1 and out_ready=0 for 20 cycles.
  - Required: stall_cnt=15 and holds there.
  - Stimulus: pulse rst_n low between edges.
  - Required: stall_cnt=0, count=0 and out_valid=0 immediately, without waiting for a clock edge.
